tx_parity_framer: RTL and testbench

- Combinational-to-registered UART transmit framer. Takes a parallel data byte and a parity-mode select, and produces a complete 11-bit serial frame in parallel: start, data LSB-first, parity, stop.
- Sits between the TX data holding register and the TX shift register.
- The shift register loads o_Data and shifts it out bit 0 first.

---
 rtl/uart_pkg.sv | 18 +
 rtl/parity_gen.sv | 29 ++
 rtl/tx_parity_framer.sv | 46 ++++
 tb/tb_tx_parity_framer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing definitions: parity mode encodings, line-level bit
// constants and the frame width helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;  // decoded as no parity

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Frame = start + data + parity/mark + stop.
    function automatic int frame_w(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/parity_gen.sv
// Parity bit generator: XOR reduction of the payload plus mode decode.
// In the no-parity modes the slot carries a mark (1) so the frame length
// never changes.
module parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_Data,
    input  logic [1:0]        i_Parity,
    output logic              o_Parity
);

    logic xor_red;

    // Select the parity slot value from the mode and the data reduction.
    always_comb begin
        xor_red  = ^i_Data;
        o_Parity = 1'b1;
        if (i_Parity == PAR_ODD) begin
            o_Parity = ~xor_red;
        end else if (i_Parity == PAR_EVEN) begin
            o_Parity = xor_red;
        end else begin
            o_Parity = 1'b1;
        end
    end

endmodule

// File: rtl/tx_parity_framer.sv
// UART transmit framer: builds start/data/parity/stop in parallel and
// registers it once per clock for the shift register to load. Bit 0 of
// the output is the first bit on the line.
module tx_parity_framer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     i_Pclk,
    input  logic                     i_Rst,
    input  logic [1:0]               i_Parity,
    input  logic [DATA_W-1:0]        i_Data,
    output logic [frame_w(DATA_W)-1:0] o_Data
);

    localparam int FRAME_W = frame_w(DATA_W);

    logic               par_bit;
    logic [FRAME_W-1:0] frame_d;
    logic [FRAME_W-1:0] frame_q;

    parity_gen #(
        .DATA_W (DATA_W)
    ) u_parity_gen (
        .i_Data   (i_Data),
        .i_Parity (i_Parity),
        .o_Parity (par_bit)
    );

    // Assemble the frame from the current inputs.
    always_comb begin
        frame_d = {STOP_BIT, par_bit, i_Data, START_BIT};
    end

    // Frame register; reset drives the idle (all-mark) line level.
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            frame_q <= '1;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign o_Data = frame_q;

endmodule

// File: tb/tb_tx_parity_framer.sv
module tb_tx_parity_framer;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = DATA_W + 3;

    logic               clk;
    logic               clk_run;
    logic               rst;
    logic [1:0]         parity;
    logic [DATA_W-1:0]  data;
    logic [FRAME_W-1:0] dout;

    int errors = 0;
    int checks = 0;

    tx_parity_framer #(.DATA_W(DATA_W)) dut (
        .i_Pclk   (clk),
        .i_Rst    (rst),
        .i_Parity (parity),
        .i_Data   (data),
        .o_Data   (dout)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Reference frame built bit by bit with an explicit ones count.
    function automatic logic [FRAME_W-1:0] ref_frame(input logic [1:0] p, input logic [DATA_W-1:0] d);
        int ones;
        logic pb;
        logic [FRAME_W-1:0] f;
        ones = 0;
        for (int k = 0; k < DATA_W; k++) if (d[k]) ones++;
        if (p == 2'b01)      pb = (ones % 2 == 0);
        else if (p == 2'b10) pb = (ones % 2 == 1);
        else                 pb = 1'b1;
        f = '0;
        f[0] = 1'b0;
        for (int k = 0; k < DATA_W; k++) f[k+1] = d[k];
        f[DATA_W+1] = pb;
        f[DATA_W+2] = 1'b1;
        return f;
    endfunction

    task automatic check(input string tag, input logic [FRAME_W-1:0] obs, input logic [FRAME_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic load(input logic [1:0] p, input logic [DATA_W-1:0] d);
        @(negedge clk);
        parity = p;
        data   = d;
        @(posedge clk);
        #1;
    endtask

    logic [FRAME_W-1:0] prev_exp;
    logic [1:0]         rp;
    logic [DATA_W-1:0]  rd;

    initial begin
        clk_run = 1'b0;
        rst     = 1'b0;
        parity  = 2'b00;
        data    = '0;
        #2;
        // Reset with no clock running
        rst = 1'b1;
        #1;
        check("reset_no_clock", dout, 11'h7FF);
        #3;
        rst = 1'b0;
        #1;
        check("reset_release_hold", dout, 11'h7FF);
        clk_run = 1'b1;

        load(2'b01, 8'h01); check("odd_01", dout, 11'h402);
        load(2'b01, 8'h03); check("odd_03", dout, 11'h606);
        load(2'b01, 8'h00); check("odd_00", dout, 11'h600);
        load(2'b10, 8'h01); check("even_01", dout, 11'h602);
        load(2'b10, 8'h03); check("even_03", dout, 11'h406);
        load(2'b10, 8'hFF); check("even_FF", dout, 11'h5FE);
        load(2'b00, 8'hA5); check("none00_A5", dout, 11'h74A);
        load(2'b11, 8'hA5); check("none11_A5", dout, 11'h74A);

        // Input change between edges must not reach the output early
        @(negedge clk);
        data = 8'h00;
        #1;
        check("no_change_between_edges", dout, 11'h74A);
        @(posedge clk);
        #1;
        check("next_edge_loads", dout, 11'h600);

        // Mid-cycle asynchronous reset
        load(2'b10, 8'h81); check("pre_reset_load", dout, 11'h502);
        @(negedge clk);
        #1;
        data   = 8'h0F;
        parity = 2'b01;
        rst    = 1'b1;
        #1;
        check("async_reset_mid_cycle", dout, 11'h7FF);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", dout, 11'h7FF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_deassert_no_edge", dout, 11'h7FF);
        @(posedge clk);
        #1;
        check("first_edge_after_reset", dout, 11'h61E);

        // Random sweep with one-cycle latency check
        prev_exp = 11'h61E;
        for (int i = 0; i < 1000; i++) begin
            rp = 2'($urandom_range(0, 3));
            rd = 8'($urandom_range(0, 255));
            @(negedge clk);
            parity = rp;
            data   = rd;
            #1;
            check("rand_before_edge", dout, prev_exp);
            @(posedge clk);
            #1;
            prev_exp = ref_frame(rp, rd);
            check("rand_after_edge", dout, prev_exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
